// File: rtl/div_unit_pkg.sv
// Shared constants and types for the EX-stage divider.
// Also holds the aluop codes EX decodes into start_i / signed_div_i.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int DOUBLE_REG_W = 64;
  typedef logic [DOUBLE_REG_W-1:0] double_reg_bus_t;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// 32-bit radix-2 restoring divider; one quotient bit per clock, 34 edges start-to-ready.
// Result {remainder, quotient} is held while start_i stays high, cleared when it drops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   w;
  logic [DATA_W-1:0]   divisor;
  logic                neg_dvd;
  logic                neg_dvs;
  logic                sgn;

  logic [DATA_W:0]     t;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;

  always_comb begin
    t     = {1'b0, w[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    a_abs = abs32(opdata1_i, signed_div_i);
    b_abs = abs32(opdata2_i, signed_div_i);
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    q_fix = (sgn && (neg_dvd ^ neg_dvs)) ? (~w[DATA_W-1:0] + 32'd1) : w[DATA_W-1:0];
    r_fix = (sgn && neg_dvd) ? (~w[2*DATA_W:DATA_W+1] + 32'd1) : w[2*DATA_W:DATA_W+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      w        <= '0;
      divisor  <= '0;
      neg_dvd  <= 1'b0;
      neg_dvs  <= 1'b0;
      sgn      <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              w       <= {{DATA_W{1'b0}}, a_abs, 1'b0};
              divisor <= b_abs;
              neg_dvd <= signed_div_i & opdata1_i[DATA_W-1];
              neg_dvs <= signed_div_i & opdata2_i[DATA_W-1];
              sgn     <= signed_div_i;
            end
          end
        end

        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
        end

        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            w        <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else if (cnt != LAST_CNT) begin
            if (t[DATA_W]) begin
              w <= {w[2*DATA_W-1:0], 1'b0};
            end else begin
              w <= {t[DATA_W-1:0], w[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
          end else begin
            state    <= DIV_END;
            cnt      <= '0;
            result_o <= {r_fix, q_fix};
            ready_o  <= DIV_RESULT_READY;
          end
        end

        DIV_END: begin
          // annul_i is deliberately ignored here; EX releases by dropping start_i.
          if (start_i == DIV_START) begin
            ready_o <= DIV_RESULT_READY;
          end else begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state    <= DIV_FREE;
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider attached to the EX stage.
- EX issues DIV/DIVU operands with a start request and holds the request (stalling the pipeline) until ready_o is high.
- EX consumes result_o as {HI=remainder, LO=quotient} and drives its HI/LO write-back with it.
- Supports signed and unsigned division, cancellation on pipeline flush, and divide-by-zero.

Parameters:
- DATA_W, 32, operand width. Only 32 is supported; the counter width and latency follow from it.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  division request; held high by EX until the result is taken
- annul_i  in  1  cancel the in-flight division (pipeline flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: on any clk edge with rst=1:
  - state goes to FREE;
  - result_o = 64'h0, ready_o = 0, internal counter and working registers cleared.
  - This applies mid-division too; the partial result is discarded.
- States (2-bit): FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 → BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 → ON. On this edge:
    - capture |opdata1_i| and |opdata2_i| (two's-complement negate only when signed_div_i=1 and bit31=1);
    - capture the sign flags and signed_div_i;
    - cnt = 0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge → END with result 64'h0.
- ON:
  - If annul_i=1: → FREE; ready_o=0, result_o=0; no result is ever produced.
  - Otherwise one iteration per edge:
    - working register W (65 bits) initialised to {32'b0, |dividend|, 1'b0};
    - t = {1'b0, W[63:32]} - {1'b0, |divisor|};
    - if t[32]=1: W = {W[63:0], 1'b0};
    - else: W = {t[31:0], W[31:0], 1'b1};
    - cnt++.
  - When cnt reaches 32, the next edge → END:
    - quotient Q = W[31:0], remainder R = W[64:33];
    - if signed and the operand signs differ, Q = -Q;
    - if signed and the dividend is negative, R = -R;
    - result_o = {R, Q}, ready_o = 1.
- END:
  - result_o and ready_o are held while start_i=1.
  - start_i=0 → FREE; ready_o=0, result_o=0.
  - annul_i in END is ignored; EX drops start_i to release.
- Latency: start sampled at edge E0.
  - Nonzero divisor: ready_o first high after edge E33.
  - Zero divisor: ready_o first high after edge E2.
- Operand inputs and signed_div_i are ignored after E0; changes mid-division have no effect.
- Semantics: quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives Q = 0x80000000, R = 0. No trap, no flag.
- start_i=0 while ON: the division continues; the result is posted in END, and END drops to FREE on the following edge because start_i=0.
- No back-to-back start: at least one FREE cycle separates operations.

Decomposition:
- Shared defines file:
  - DivFree / DivByZero / DivOn / DivEnd (2'b00..2'b11);
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - DoubleRegBus 63:0;
  - EXE_DIV_OP and EXE_DIVU_OP aluop codes, used by EX to drive start_i and signed_div_i.
- Single module, no sub-module. Absolute value and sign fix-up are inline expressions.

Test Plan:
- Unsigned: signed=0, op1 = 0xFFFFFFFF, op2 = 0x00000010, start held.
  - Required: ready_o rises exactly 33 edges after start; result_o = {0x0000000F, 0x0FFFFFFF}.
  - After start_i drops, ready_o = 0 and result_o = 0 on the next edge.
- Signed, all sign combinations:
  - -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}
  - 7 / -2 → {0x00000001, 0xFFFFFFFD}
  - -7 / -2 → {0xFFFFFFFF, 0x00000003}
  - 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}
- Divide by zero: op2 = 0, start held.
  - Required: ready_o high after 2 edges; result_o = 64'h0; FREE again after start_i drops.
- Annul: start 100 / 3, assert annul_i for one cycle at cnt = 10.
  - Required: returns to FREE; ready_o never rises.
  - A new start 100 / 3 then returns {0x00000001, 0x00000021} after 33 edges.
- Reset mid-operation: rst=1 at cnt = 20, for one edge.
  - Required: state FREE, ready_o = 0, result_o = 0 on that edge; no later ready pulse.
- Operand change mid-division: op1/op2 changed to random values while ON.
  - Required: result matches the operands captured at E0.
